// File: rtl/hazard_pkg.sv
// Shared types for the front-end hazard controller: FSM encoding, priority-cause
// enum, debug snapshot struct and parameter defaults.
package hazard_pkg;

  localparam int REG_W_DEF          = 9;
  localparam int MAX_STORES_DEF     = 4;
  localparam int RECOVER_CYCLES_DEF = 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } hz_state_e;

  // Which priority level is steering the strobes this cycle.
  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_MEM_BUSY   = 3'd1,
    CAUSE_MISPREDICT = 3'd2,
    CAUSE_RECOVER    = 3'd3,
    CAUSE_FENCE_FULL = 3'd4,
    CAUSE_LOAD_USE   = 3'd5
  } hz_cause_e;

  typedef struct packed {
    hz_state_e  state;
    hz_cause_e  cause;
    logic [2:0] rc_cnt;
  } hz_dbg_t;

  // Counter width able to hold 0..max_stores inclusive.
  function automatic int cnt_width(input int max_stores);
    int w;
    w = $clog2(max_stores + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_store_tracker.sv
// Saturating up/down counter of stores accepted by memory but not yet
// acknowledged by the bus; reports empty/full for the fence and store-full logic.
module store_tracker
  import hazard_pkg::*;
#(
  parameter int MAX_STORES = MAX_STORES_DEF,
  localparam int CNT_W     = cnt_width(MAX_STORES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_in,
  input  logic             ack_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             empty_out,
  output logic             full_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STORES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign empty_out = (cnt_q == '0);
  assign full_out  = (cnt_q == CNT_MAX);
  assign cnt_out   = cnt_q;

  // Issue and ack in the same cycle cancel; both directions saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_in && !ack_in && !full_out) begin
      cnt_d = cnt_q + 1'b1;
    end else if (ack_in && !issue_in && !empty_out) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_no_ack_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(ack_in && !issue_in && empty_out)
  );

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end stall/flush sequencer with store-drain fence handling and mispredict
// recovery window. Perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W          = REG_W_DEF,
  parameter int MAX_STORES     = MAX_STORES_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_in,
  input  logic             rs1_read_in,
  input  logic [REG_W-1:0] rs2_in,
  input  logic             rs2_read_in,
  input  logic             fence_in,
  input  logic             store_in,
  input  logic             ex_valid_in,
  input  logic             ex_mem_read_in,
  input  logic [REG_W-1:0] ex_rd_in,
  input  logic             mispredict_in,
  input  logic             store_issue_in,
  input  logic             store_ack_in,
  input  logic             mem_busy_in,
  output logic             stall_fetch_out,
  output logic             stall_decode_out,
  output logic             stall_execute_out,
  output logic             flush_fetch_out,
  output logic             flush_decode_out,
  output logic             flush_execute_out,
  output logic             fence_busy_out,
  output logic [31:0]      stall_cycles_out,
  output logic [31:0]      flush_events_out
);

  localparam int         CNT_W   = cnt_width(MAX_STORES);
  localparam logic [2:0] RC_INIT = 3'(RECOVER_CYCLES);

  if (RECOVER_CYCLES < 0 || RECOVER_CYCLES > 7) begin : g_bad_recover_cycles
    $error("hazard_ctrl: RECOVER_CYCLES must be in 0..7");
  end

  hz_state_e  state_q, state_d;
  logic [2:0] rc_cnt_q, rc_cnt_d;
  hz_cause_e  cause;
  hz_dbg_t    dbg;

  logic [CNT_W-1:0] st_cnt;
  logic             st_empty;
  logic             st_full;

  store_tracker #(
    .MAX_STORES (MAX_STORES)
  ) u_store_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_in  (store_issue_in),
    .ack_in    (store_ack_in),
    .cnt_out   (st_cnt),
    .empty_out (st_empty),
    .full_out  (st_full)
  );

  logic fence_trig;
  logic full_trig;
  logic drained;
  logic drain_hold;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  // A store issuing this cycle means memory is not drained even at st_cnt==0.
  assign drained    = st_empty && !store_issue_in;
  assign fence_trig = fence_in && !drained;
  assign full_trig  = store_in && st_full;
  assign drain_hold = (state_q == DRAIN) && !drained;

  assign rs1_hit  = rs1_read_in && (rs1_in == ex_rd_in);
  assign rs2_hit  = rs2_read_in && (rs2_in == ex_rd_in);
  assign load_use = ex_valid_in && ex_mem_read_in && (ex_rd_in != '0) &&
                    (rs1_hit || rs2_hit);

  always_comb begin
    cause = CAUSE_NONE;
    if (mem_busy_in) begin
      cause = CAUSE_MEM_BUSY;
    end else if (mispredict_in) begin
      cause = CAUSE_MISPREDICT;
    end else if (state_q == RECOVER) begin
      cause = CAUSE_RECOVER;
    end else if (fence_trig || full_trig || drain_hold) begin
      cause = CAUSE_FENCE_FULL;
    end else if (load_use) begin
      cause = CAUSE_LOAD_USE;
    end
  end

  always_comb begin
    state_d  = state_q;
    rc_cnt_d = rc_cnt_q;
    unique case (cause)
      CAUSE_MEM_BUSY: begin
        state_d  = state_q;
        rc_cnt_d = rc_cnt_q;
      end
      CAUSE_MISPREDICT: begin
        // Also abandons any DRAIN; the fence is refetched behind the redirect.
        if (RECOVER_CYCLES > 0) begin
          state_d  = RECOVER;
          rc_cnt_d = RC_INIT;
        end else begin
          state_d  = RUN;
          rc_cnt_d = 3'd0;
        end
      end
      CAUSE_RECOVER: begin
        rc_cnt_d = (rc_cnt_q == 3'd0) ? 3'd0 : rc_cnt_q - 3'd1;
        if (rc_cnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end
      CAUSE_FENCE_FULL: begin
        if (fence_trig || drain_hold) begin
          state_d = DRAIN;
        end
      end
      default: begin
        // Reaching here from DRAIN means the stores have drained.
        if (state_q == DRAIN) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      rc_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      rc_cnt_q <= rc_cnt_d;
    end
  end

  always_comb begin
    stall_fetch_out   = 1'b0;
    stall_decode_out  = 1'b0;
    stall_execute_out = 1'b0;
    flush_fetch_out   = 1'b0;
    flush_decode_out  = 1'b0;
    flush_execute_out = 1'b0;
    fence_busy_out    = (state_q == DRAIN);
    unique case (cause)
      CAUSE_MEM_BUSY: begin
        stall_fetch_out   = 1'b1;
        stall_decode_out  = 1'b1;
        stall_execute_out = 1'b1;
      end
      CAUSE_MISPREDICT, CAUSE_RECOVER: begin
        flush_fetch_out  = 1'b1;
        flush_decode_out = 1'b1;
      end
      CAUSE_FENCE_FULL: begin
        stall_fetch_out  = 1'b1;
        stall_decode_out = 1'b1;
      end
      CAUSE_LOAD_USE: begin
        // Decode keeps advancing but emits a bubble; fetch holds its slot.
        stall_fetch_out  = 1'b1;
        flush_decode_out = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      stall_fetch_out   = 1'b0;
      stall_decode_out  = 1'b0;
      stall_execute_out = 1'b0;
      flush_fetch_out   = 1'b1;
      flush_decode_out  = 1'b1;
      flush_execute_out = 1'b1;
      fence_busy_out    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_fetch_out) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (mispredict_in) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles_out = stall_cycles_q;
  assign flush_events_out = flush_events_q;
`else
  assign stall_cycles_out = 32'd0;
  assign flush_events_out = 32'd0;
`endif

  assign dbg = '{state: state_q, cause: cause, rc_cnt: rc_cnt_q};

  a_recover_has_count: assert property (
    @(posedge clk) disable iff (!rst_n)
    (dbg.state == RECOVER) |-> (dbg.rc_cnt != 3'd0)
  );

  a_busy_never_flushes: assert property (
    @(posedge clk) disable iff (!rst_n)
    (dbg.cause == CAUSE_MEM_BUSY) |-> !(flush_fetch_out || flush_decode_out)
  );

  a_execute_flush_reset_only: assert property (
    @(posedge clk) disable iff (!rst_n)
    !flush_execute_out
  );

  a_store_count_bounded: assert property (
    @(posedge clk) disable iff (!rst_n)
    st_cnt <= CNT_W'(MAX_STORES)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl (MAX_STORES=4, RECOVER_CYCLES=1)
// plus a hand-written asynchronous-reset-during-recovery sequence.
module tb_hazard_ctrl;

  localparam int REG_W = 9;

  logic             clk;
  logic             rst_n;
  logic [REG_W-1:0] rs1_in, rs2_in, ex_rd_in;
  logic             rs1_read_in, rs2_read_in, fence_in, store_in;
  logic             ex_valid_in, ex_mem_read_in, mispredict_in;
  logic             store_issue_in, store_ack_in, mem_busy_in;
  logic             stall_fetch_out, stall_decode_out, stall_execute_out;
  logic             flush_fetch_out, flush_decode_out, flush_execute_out;
  logic             fence_busy_out;
  logic [31:0]      stall_cycles_out, flush_events_out;

  hazard_ctrl #(
    .REG_W          (REG_W),
    .MAX_STORES     (4),
    .RECOVER_CYCLES (1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rs1_in            (rs1_in),
    .rs1_read_in       (rs1_read_in),
    .rs2_in            (rs2_in),
    .rs2_read_in       (rs2_read_in),
    .fence_in          (fence_in),
    .store_in          (store_in),
    .ex_valid_in       (ex_valid_in),
    .ex_mem_read_in    (ex_mem_read_in),
    .ex_rd_in          (ex_rd_in),
    .mispredict_in     (mispredict_in),
    .store_issue_in    (store_issue_in),
    .store_ack_in      (store_ack_in),
    .mem_busy_in       (mem_busy_in),
    .stall_fetch_out   (stall_fetch_out),
    .stall_decode_out  (stall_decode_out),
    .stall_execute_out (stall_execute_out),
    .flush_fetch_out   (flush_fetch_out),
    .flush_decode_out  (flush_decode_out),
    .flush_execute_out (flush_execute_out),
    .fence_busy_out    (fence_busy_out),
    .stall_cycles_out  (stall_cycles_out),
    .flush_events_out  (flush_events_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector order: {stall_f, stall_d, stall_e, flush_f, flush_d, flush_e, fence_busy}
  typedef struct {
    string            name;
    logic [REG_W-1:0] rs1;
    logic             rs1r;
    logic [REG_W-1:0] rs2;
    logic             rs2r;
    logic             exv;
    logic             exld;
    logic [REG_W-1:0] exrd;
    logic             fence;
    logic             store;
    logic             mis;
    logic             iss;
    logic             ack;
    logic             busy;
    logic [6:0]       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;
  int   exp_stall_cycles;
  int   exp_flush_events;

  function automatic vec_t mk(string nm, int rs1, bit rs1r, int rs2, bit rs2r,
                              bit exv, bit exld, int exrd, bit fence, bit store,
                              bit mis, bit iss, bit ack, bit busy, logic [6:0] exp);
    vec_t v;
    v.name = nm;  v.rs1 = REG_W'(rs1); v.rs1r = rs1r; v.rs2 = REG_W'(rs2);
    v.rs2r = rs2r; v.exv = exv; v.exld = exld; v.exrd = REG_W'(exrd);
    v.fence = fence; v.store = store; v.mis = mis; v.iss = iss; v.ack = ack;
    v.busy = busy; v.exp = exp;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rs1_in = v.rs1;   rs1_read_in = v.rs1r; rs2_in = v.rs2; rs2_read_in = v.rs2r;
    ex_valid_in = v.exv; ex_mem_read_in = v.exld; ex_rd_in = v.exrd;
    fence_in = v.fence; store_in = v.store; mispredict_in = v.mis;
    store_issue_in = v.iss; store_ack_in = v.ack; mem_busy_in = v.busy;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {stall_fetch_out, stall_decode_out, stall_execute_out,
            flush_fetch_out, flush_decode_out, flush_execute_out, fence_busy_out};
  endfunction

  task automatic check_perf(input string name, input int stalls, input int flushes);
`ifdef HAZARD_PERF_EN
    check({name, "_stall_cycles"}, stall_cycles_out, 32'(stalls));
    check({name, "_flush_events"}, flush_events_out, 32'(flushes));
`else
    check({name, "_stall_cycles"}, stall_cycles_out, 32'd0);
    check({name, "_flush_events"}, flush_events_out, 32'd0);
`endif
  endtask

  vec_t idle;

  initial begin
    n_checks = 0; n_errors = 0; exp_stall_cycles = 0; exp_flush_events = 0;
    idle = mk("idle", 0,0, 0,0, 0,0,0, 0,0, 0,0,0,0, 7'b0000000);

    //              name           rs1 r  rs2 r  exv ld rd  fn st ms is ak by  expected
    vecs.push_back(mk("idle",         0,0,  0,0,  0,0,0,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("lu_rs2",       0,0,  5,1,  1,1,5,  0,0, 0,0,0,0, 7'b1000100));
    vecs.push_back(mk("after_lu",     0,0,  0,0,  0,0,0,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("lu_rd0",       0,0,  0,1,  1,1,0,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("lu_rs1",       7,1,  0,0,  1,1,7,  0,0, 0,0,0,0, 7'b1000100));
    vecs.push_back(mk("lu_no_read",   7,0,  0,0,  1,1,7,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("lu_not_load",  7,1,  0,0,  1,0,7,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("issue_a",      0,0,  0,0,  0,0,0,  0,0, 0,1,0,0, 7'b0000000));
    vecs.push_back(mk("issue_b",      0,0,  0,0,  0,0,0,  0,0, 0,1,0,0, 7'b0000000));
    vecs.push_back(mk("fence_trig",   0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b1100000));
    vecs.push_back(mk("drain_ack1",   0,0,  0,0,  0,0,0,  1,0, 0,0,1,0, 7'b1100001));
    vecs.push_back(mk("drain_ack2",   0,0,  0,0,  0,0,0,  1,0, 0,0,1,0, 7'b1100001));
    vecs.push_back(mk("drain_release",0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b0000001));
    vecs.push_back(mk("fence_pass",   0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b0000000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("fill",       0,0,  0,0,  0,0,0,  0,0, 0,1,0,0, 7'b0000000));
    vecs.push_back(mk("full_stall",   0,0,  0,0,  0,0,0,  0,1, 0,0,0,0, 7'b1100000));
    vecs.push_back(mk("full_ack",     0,0,  0,0,  0,0,0,  0,1, 0,0,1,0, 7'b1100000));
    vecs.push_back(mk("full_release", 0,0,  0,0,  0,0,0,  0,1, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("refill",       0,0,  0,0,  0,0,0,  0,0, 0,1,0,0, 7'b0000000));
    vecs.push_back(mk("issue_at_max", 0,0,  0,0,  0,0,0,  0,0, 0,1,0,0, 7'b0000000));
    vecs.push_back(mk("sat_full",     0,0,  0,0,  0,0,0,  0,1, 0,0,0,0, 7'b1100000));
    vecs.push_back(mk("iss_ack_full", 0,0,  0,0,  0,0,0,  0,1, 0,1,1,0, 7'b1100000));
    vecs.push_back(mk("still_full",   0,0,  0,0,  0,0,0,  0,1, 0,0,0,0, 7'b1100000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("empty_out",  0,0,  0,0,  0,0,0,  0,0, 0,0,1,0, 7'b0000000));
    vecs.push_back(mk("issue_c",      0,0,  0,0,  0,0,0,  0,0, 0,1,0,0, 7'b0000000));
    vecs.push_back(mk("fence2",       0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b1100000));
    vecs.push_back(mk("mis_in_drain", 0,0,  0,0,  0,0,0,  1,0, 1,0,0,0, 7'b0001101));
    vecs.push_back(mk("recover1",     0,0,  0,0,  0,0,0,  0,0, 0,0,0,0, 7'b0001100));
    vecs.push_back(mk("post_recover", 0,0,  0,0,  0,0,0,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("fence_refetch",0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b1100000));
    vecs.push_back(mk("refetch_ack",  0,0,  0,0,  0,0,0,  1,0, 0,0,1,0, 7'b1100001));
    vecs.push_back(mk("refetch_go",   0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b0000001));
    vecs.push_back(mk("busy_lu",      3,1,  0,0,  1,1,3,  0,0, 0,0,0,1, 7'b1110000));
    vecs.push_back(mk("busy_iss_ack", 0,0,  0,0,  0,0,0,  0,0, 0,1,1,1, 7'b1110000));
    vecs.push_back(mk("cnt_unchanged",0,0,  0,0,  0,0,0,  1,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("mis_run",      0,0,  0,0,  0,0,0,  0,0, 1,0,0,0, 7'b0001100));
    vecs.push_back(mk("busy_freeze",  0,0,  0,0,  0,0,0,  0,0, 0,0,0,1, 7'b1110000));
    vecs.push_back(mk("recover_late", 0,0,  0,0,  0,0,0,  0,0, 0,0,0,0, 7'b0001100));
    vecs.push_back(mk("back_to_run",  0,0,  0,0,  0,0,0,  0,0, 0,0,0,0, 7'b0000000));
    vecs.push_back(mk("mis_over_lu",  4,1,  0,0,  1,1,4,  0,0, 1,0,0,0, 7'b0001100));
    vecs.push_back(mk("mis_reload",   0,0,  0,0,  0,0,0,  0,0, 1,0,0,0, 7'b0001100));
    vecs.push_back(mk("rec_over_lu",  4,1,  0,0,  1,1,4,  0,0, 0,0,0,0, 7'b0001100));
    vecs.push_back(mk("lu_after_rec", 4,1,  0,0,  1,1,4,  0,0, 0,0,0,0, 7'b1000100));

    // Reset state, sampled while rst_n is low with a busy hazard present.
    rst_n = 1'b0;
    drive(idle);
    mem_busy_in = 1'b1;
    #3;
    check("reset_outputs", 32'(outs()), 32'(7'b0001110));
    check_perf("reset", 0, 0);
    mem_busy_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      if (vecs[i].exp[6]) exp_stall_cycles++;
      if (vecs[i].mis) exp_flush_events++;
    end

    @(negedge clk);
    drive(idle);
    #2;
    check_perf("after_table", exp_stall_cycles, exp_flush_events);

    // Asynchronous reset while in RECOVER with one store outstanding.
    @(negedge clk);
    drive(idle); store_issue_in = 1'b1;
    #2;
    check("pre_rst_issue", 32'(outs()), 32'(7'b0000000));
    @(negedge clk);
    drive(idle); mispredict_in = 1'b1;
    #2;
    check("pre_rst_mis", 32'(outs()), 32'(7'b0001100));
    @(negedge clk);
    drive(idle);
    #2;
    check("in_recover", 32'(outs()), 32'(7'b0001100));
    #1;
    rst_n = 1'b0;
    mem_busy_in = 1'b1;
    #1;
    check("async_reset", 32'(outs()), 32'(7'b0001110));
    check_perf("async_reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle); fence_in = 1'b1;
    #2;
    check("post_rst_fence", 32'(outs()), 32'(7'b0000000));
    @(negedge clk);
    drive(idle);
    #2;
    check("post_rst_idle", 32'(outs()), 32'(7'b0000000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
